aes_core_arbiter: RTL and testbench
===================================

Name: aes_core_arbiter

Overview:
- Sequencer and round-robin arbiter that shares one AES-192 engine between two block requesters.
- Accepts 128-bit text blocks over valid/ready and pulses the engine start.
- Waits for the engine's out_valid, with a watchdog timeout, and returns the 128-bit result tagged with the requester ID.
- Sits between the bus-side register front-ends and the AES core. Key and IV wiring to the core is outside this block.

Parameters:
- DATA_W, 128, text and result width in bits.
- TIMEOUT, 64, maximum WAIT cycles before the operation is aborted with an error. Legal range 2..65535.
- CNT_W, $clog2(TIMEOUT+1), watchdog counter width. Derived; do not override.

Ports:
- clk_i  in  1  clock; all logic on the rising edge.
- rst_i  in  1  synchronous reset, active-high.
- req0_valid_i  in  1  requester 0 has a block.
- req0_data_i  in  DATA_W  requester 0 block.
- req0_ready_o  out  1  requester 0 block accepted this cycle when valid is also high.
- req1_valid_i  in  1  requester 1 has a block.
- req1_data_i  in  DATA_W  requester 1 block.
- req1_ready_o  out  1  requester 1 block accepted this cycle when valid is also high.
- rsp_valid_o  out  1  result available.
- rsp_ready_i  in  1  consumer takes the result.
- rsp_data_o  out  DATA_W  result block; 0 on error.
- rsp_id_o  out  1  requester that owns the result.
- rsp_err_o  out  1  watchdog timeout occurred.
- core_start_o  out  1  one-cycle start pulse to the AES core.
- core_text_o  out  DATA_W  block to the core; held stable from ISSUE until leaving WAIT.
- core_ct_i  in  DATA_W  core output.
- core_valid_i  in  1  core out_valid. May be sticky-high from the previous operation.
- busy_o  out  1  FSM is not in IDLE.

Behaviour:
- Reset (rst_i=1 at a clock edge):
  - state=IDLE; last_grant=1, so requester 0 wins first; text_q=0; result_q=0; err_q=0; id_q=0; timer=0; seen_low=0.
  - All outputs 0.
  - Reset mid-operation abandons the block silently: no response is issued and the core is not signalled.
- IDLE:
  - Grant is combinational. If exactly one valid, grant it. If both valid, grant the requester != last_grant.
  - reqN_ready_o=1 only for the granted requester, and only in IDLE.
  - On valid&ready: latch text_q and id_q, set last_grant=id_q, go to ISSUE. Data is captured in this cycle.
- ISSUE (1 cycle):
  - core_start_o=1; timer=0; seen_low=0; go to WAIT.
- WAIT:
  - core_start_o=0.
  - seen_low is set when core_valid_i==0 is sampled. core_valid_i is honoured only when seen_low is already 1. This rejects a stale sticky valid from the previous operation.
  - Honoured valid: result_q=core_ct_i, err_q=0, go to RESP.
  - Otherwise timer increments. When timer==TIMEOUT-1 and there is no honoured valid: result_q=0, err_q=1, go to RESP.
  - A valid arriving in the same cycle as the timeout wins, so err=0.
- RESP:
  - rsp_valid_o=1; rsp_data_o, rsp_id_o and rsp_err_o are stable until handshake.
  - On rsp_ready_i=1, go to IDLE. The next request can be accepted one cycle later; there is no same-cycle turnaround.
  - rsp_valid_o never drops without a handshake.
- Latency: request accepted at cycle T; core_start_o at T+1; WAIT starts at T+2; rsp_valid_o appears 1 cycle after the honoured core_valid_i.
- Fairness: with both requesters continuously valid, grants alternate 0,1,0,1. A requester holding valid waits at most one operation.
- Requester valid dropping while not granted is legal; no data is captured.
- busy_o = (state != IDLE).

Test Plan:
- Reset, then req0 valid with data 0x00112233_44556677_8899AABB_CCDDEEFF. Core drives valid=0 for 3 cycles, then valid=1 with ct 0x6BC1BEE2_2E409F96_E93D7E11_7393172A. Expect core_start_o one pulse at T+1, and rsp_valid_o with that data, id=0, err=0.
- Both requesters continuously valid for 4 operations, core answering after 5 cycles. Expect grant order 0,1,0,1 and rsp_id_o sequence 0,1,0,1.
- Hold core_valid_i=1 throughout, a sticky stale valid. Expect no result capture, and after TIMEOUT=64 WAIT cycles rsp_err_o=1, rsp_data_o=0.
- core_valid_i first goes low-then-high exactly at timer==63. Expect err=0 and ct captured.
- Hold rsp_ready_i=0 for 10 cycles with req1 valid. Expect rsp outputs stable, req1_ready_o=0 throughout, and req1 accepted one cycle after the handshake.
- Assert rst_i during WAIT. Expect the next cycle busy_o=0 and no rsp_valid_o. Then a new req0 completes normally.

Source files
------------

// File: rtl/aes_core_arbiter.sv
// Round-robin sequencer sharing one AES-192 engine between two block requesters.
module aes_core_arbiter #(
  parameter int unsigned DATA_W  = 128,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              req0_valid_i,
  input  logic [DATA_W-1:0] req0_data_i,
  output logic              req0_ready_o,
  input  logic              req1_valid_i,
  input  logic [DATA_W-1:0] req1_data_i,
  output logic              req1_ready_o,
  output logic              rsp_valid_o,
  input  logic              rsp_ready_i,
  output logic [DATA_W-1:0] rsp_data_o,
  output logic              rsp_id_o,
  output logic              rsp_err_o,
  output logic              core_start_o,
  output logic [DATA_W-1:0] core_text_o,
  input  logic [DATA_W-1:0] core_ct_i,
  input  logic              core_valid_i,
  output logic              busy_o
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] TIMER_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_e;

  state_e             state_q, state_d;
  logic               last_grant_q, last_grant_d;
  logic [DATA_W-1:0]  text_q, text_d;
  logic [DATA_W-1:0]  result_q, result_d;
  logic               err_q, err_d;
  logic               id_q, id_d;
  logic [CNT_W-1:0]   timer_q, timer_d;
  logic               seen_low_q, seen_low_d;

  logic               gnt0, gnt1;
  logic               honoured;

  // Combinational grant: a lone requester wins, a tie goes to the one not served last.
  always_comb begin
    gnt0 = req0_valid_i && (!req1_valid_i || last_grant_q);
    gnt1 = req1_valid_i && (!req0_valid_i || !last_grant_q);
  end

  // A core valid only counts once a low has been observed in this operation,
  // which filters out a sticky valid left over from the previous block.
  always_comb begin
    honoured = core_valid_i && seen_low_q;
  end

  // Next-state and datapath updates.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    text_d       = text_q;
    result_d     = result_q;
    err_d        = err_q;
    id_d         = id_q;
    timer_d      = timer_q;
    seen_low_d   = seen_low_q;

    unique case (state_q)
      S_IDLE: begin
        if (gnt0) begin
          text_d       = req0_data_i;
          id_d         = 1'b0;
          last_grant_d = 1'b0;
          state_d      = S_ISSUE;
        end else if (gnt1) begin
          text_d       = req1_data_i;
          id_d         = 1'b1;
          last_grant_d = 1'b1;
          state_d      = S_ISSUE;
        end
      end

      S_ISSUE: begin
        timer_d    = '0;
        seen_low_d = 1'b0;
        state_d    = S_WAIT;
      end

      S_WAIT: begin
        seen_low_d = seen_low_q | ~core_valid_i;
        if (honoured) begin
          result_d = core_ct_i;
          err_d    = 1'b0;
          state_d  = S_RESP;
        end else if (timer_q == TIMER_LAST) begin
          result_d = '0;
          err_d    = 1'b1;
          state_d  = S_RESP;
        end else begin
          timer_d = timer_q + CNT_W'(1);
        end
      end

      S_RESP: begin
        if (rsp_ready_i) begin
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State register with synchronous reset; reset abandons any block in flight.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= S_IDLE;
      last_grant_q <= 1'b1;
      text_q       <= '0;
      result_q     <= '0;
      err_q        <= 1'b0;
      id_q         <= 1'b0;
      timer_q      <= '0;
      seen_low_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      text_q       <= text_d;
      result_q     <= result_d;
      err_q        <= err_d;
      id_q         <= id_d;
      timer_q      <= timer_d;
      seen_low_q   <= seen_low_d;
    end
  end

  // Outputs.
  always_comb begin
    req0_ready_o = (state_q == S_IDLE) && gnt0;
    req1_ready_o = (state_q == S_IDLE) && gnt1;
    rsp_valid_o  = (state_q == S_RESP);
    rsp_data_o   = result_q;
    rsp_id_o     = id_q;
    rsp_err_o    = err_q;
    core_start_o = (state_q == S_ISSUE);
    core_text_o  = text_q;
    busy_o       = (state_q != S_IDLE);
  end

endmodule

// File: tb/tb_aes_core_arbiter.sv
module tb_aes_core_arbiter;

  localparam int unsigned DATA_W  = 128;
  localparam int unsigned TIMEOUT = 64;

  logic              clk = 1'b0;
  logic              rst;
  logic              req0_valid, req1_valid;
  logic [DATA_W-1:0] req0_data, req1_data;
  logic              req0_ready, req1_ready;
  logic              rsp_valid, rsp_ready;
  logic [DATA_W-1:0] rsp_data;
  logic              rsp_id, rsp_err;
  logic              core_start;
  logic [DATA_W-1:0] core_text;
  logic [DATA_W-1:0] core_ct;
  logic              core_valid;
  logic              busy;

  int unsigned checks = 0;
  int unsigned errors = 0;

  aes_core_arbiter #(
    .DATA_W (DATA_W),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .req0_valid_i(req0_valid),
    .req0_data_i (req0_data),
    .req0_ready_o(req0_ready),
    .req1_valid_i(req1_valid),
    .req1_data_i (req1_data),
    .req1_ready_o(req1_ready),
    .rsp_valid_o (rsp_valid),
    .rsp_ready_i (rsp_ready),
    .rsp_data_o  (rsp_data),
    .rsp_id_o    (rsp_id),
    .rsp_err_o   (rsp_err),
    .core_start_o(core_start),
    .core_text_o (core_text),
    .core_ct_i   (core_ct),
    .core_valid_i(core_valid),
    .busy_o      (busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [DATA_W-1:0] obs, input logic [DATA_W-1:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    #1;
  endtask

  localparam logic [DATA_W-1:0] PT0 = 128'h00112233_44556677_8899AABB_CCDDEEFF;
  localparam logic [DATA_W-1:0] CT0 = 128'h6BC1BEE2_2E409F96_E93D7E11_7393172A;
  localparam logic [DATA_W-1:0] PTA = 128'hAAAA0000_11112222_33334444_55556666;
  localparam logic [DATA_W-1:0] PTB = 128'hBBBB7777_88889999_AAAABBBB_CCCCDDDD;
  localparam logic [DATA_W-1:0] CTZ = 128'hAE2D8A57_1E03AC9C_9EB76FAC_45AF8E51;
  localparam logic [DATA_W-1:0] PTW = 128'h30C81C46_A35CE411_E5FBC119_1A0A52EF;
  localparam logic [DATA_W-1:0] PTD = 128'hF69F2445_DF4F9B17_AD2B417B_E66C3710;
  localparam logic [DATA_W-1:0] CTD = 128'h7B0C785E_27E8AD3F_82232071_04725DD4;

  initial begin
    logic exp_id;
    logic [DATA_W-1:0] ct_i;

    rst        = 1'b0;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    req0_data  = '0;
    req1_data  = '0;
    rsp_ready  = 1'b0;
    core_ct    = '0;
    core_valid = 1'b0;

    // Reset state
    do_reset();
    chk("rst_busy", DATA_W'(busy), '0);
    chk("rst_rsp_valid", DATA_W'(rsp_valid), '0);
    chk("rst_core_start", DATA_W'(core_start), '0);
    chk("rst_rsp_data", rsp_data, '0);
    chk("rst_core_text", core_text, '0);
    chk("rst_ready0", DATA_W'(req0_ready), '0);

    // Single req0 operation, core answers after 3 low cycles
    req0_valid = 1'b1;
    req0_data  = PT0;
    #1;
    chk("t1_ready0", DATA_W'(req0_ready), 1);
    chk("t1_ready1", DATA_W'(req1_ready), 0);
    tick();                      // accepted at T, now in ISSUE
    req0_valid = 1'b0;
    chk("t1_start_T1", DATA_W'(core_start), 1);
    chk("t1_text", core_text, PT0);
    chk("t1_busy", DATA_W'(busy), 1);
    tick();                      // WAIT w0
    chk("t1_start_once", DATA_W'(core_start), 0);
    tick();
    tick();
    tick();                      // w3
    core_valid = 1'b1;
    core_ct    = CT0;
    #1;
    chk("t1_no_early_rsp", DATA_W'(rsp_valid), 0);
    tick();
    chk("t1_rsp_valid", DATA_W'(rsp_valid), 1);
    chk("t1_rsp_data", rsp_data, CT0);
    chk("t1_rsp_id", DATA_W'(rsp_id), 0);
    chk("t1_rsp_err", DATA_W'(rsp_err), 0);
    rsp_ready = 1'b1;
    tick();
    rsp_ready  = 1'b0;
    core_valid = 1'b0;
    #1;
    chk("t1_idle", DATA_W'(busy), 0);

    // Fairness: both requesters continuously valid, four operations
    do_reset();
    req0_valid = 1'b1;
    req0_data  = PTA;
    req1_valid = 1'b1;
    req1_data  = PTB;
    for (int i = 0; i < 4; i++) begin
      exp_id = (i % 2 == 1);
      ct_i   = {32'hC0DE0000 + 32'(i), 96'h0};
      #1;
      chk("t2_ready0", DATA_W'(req0_ready), DATA_W'(!exp_id));
      chk("t2_ready1", DATA_W'(req1_ready), DATA_W'(exp_id));
      tick();
      chk("t2_text", core_text, exp_id ? PTB : PTA);
      tick();
      repeat (4) tick();
      core_valid = 1'b1;
      core_ct    = ct_i;
      tick();
      chk("t2_rsp_valid", DATA_W'(rsp_valid), 1);
      chk("t2_rsp_id", DATA_W'(rsp_id), DATA_W'(exp_id));
      chk("t2_rsp_data", rsp_data, ct_i);
      chk("t2_resp_ready_low", DATA_W'({req0_ready, req1_ready}), 0);
      rsp_ready = 1'b1;
      tick();
      rsp_ready  = 1'b0;
      core_valid = 1'b0;
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;

    // Sticky stale valid: no capture, timeout after TIMEOUT WAIT cycles
    do_reset();
    core_valid = 1'b1;
    core_ct    = CT0;
    req1_valid = 1'b1;
    req1_data  = PTB;
    #1;
    chk("t3_ready1", DATA_W'(req1_ready), 1);
    tick();
    req1_valid = 1'b0;
    tick();                      // w0
    repeat (TIMEOUT - 1) tick(); // w63
    chk("t3_no_rsp_at_last", DATA_W'(rsp_valid), 0);
    tick();
    chk("t3_rsp_valid", DATA_W'(rsp_valid), 1);
    chk("t3_rsp_err", DATA_W'(rsp_err), 1);
    chk("t3_rsp_data", rsp_data, '0);
    chk("t3_rsp_id", DATA_W'(rsp_id), 1);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;

    // Low-then-high exactly at the last timer value: valid wins
    req0_valid = 1'b1;
    req0_data  = PTA;
    #1;
    chk("t4_ready0", DATA_W'(req0_ready), 1);
    tick();
    req0_valid = 1'b0;
    tick();                      // w0, core_valid still sticky high
    repeat (TIMEOUT - 2) tick(); // w62
    core_valid = 1'b0;
    tick();                      // w63
    core_valid = 1'b1;
    core_ct    = CTZ;
    #1;
    chk("t4_no_rsp_yet", DATA_W'(rsp_valid), 0);
    tick();
    chk("t4_rsp_valid", DATA_W'(rsp_valid), 1);
    chk("t4_rsp_err", DATA_W'(rsp_err), 0);
    chk("t4_rsp_data", rsp_data, CTZ);
    chk("t4_rsp_id", DATA_W'(rsp_id), 0);
    core_valid = 1'b0;

    // Back-pressure: response held for 10 cycles while req1 waits
    req1_valid = 1'b1;
    req1_data  = PTW;
    for (int i = 0; i < 10; i++) begin
      #1;
      chk("t5_hold_valid", DATA_W'(rsp_valid), 1);
      chk("t5_hold_data", rsp_data, CTZ);
      chk("t5_hold_meta", DATA_W'({rsp_id, rsp_err}), 0);
      chk("t5_ready1_low", DATA_W'(req1_ready), 0);
      tick();
    end
    rsp_ready = 1'b1;
    #1;
    chk("t5_ready1_at_hs", DATA_W'(req1_ready), 0);
    tick();
    rsp_ready = 1'b0;
    #1;
    chk("t5_ready1_after", DATA_W'(req1_ready), 1);
    tick();
    req1_valid = 1'b0;
    chk("t5_start", DATA_W'(core_start), 1);
    chk("t5_text", core_text, PTW);

    // Reset during WAIT abandons the block silently
    tick();                      // w0
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    chk("t6_busy", DATA_W'(busy), 0);
    chk("t6_rsp_valid", DATA_W'(rsp_valid), 0);
    core_valid = 1'b1;
    core_ct    = CTZ;
    tick();
    tick();
    chk("t6_still_idle", DATA_W'({busy, rsp_valid, core_start}), 0);
    core_valid = 1'b0;

    req0_valid = 1'b1;
    req0_data  = PTD;
    #1;
    chk("t6_ready0", DATA_W'(req0_ready), 1);
    tick();
    req0_valid = 1'b0;
    chk("t6_start", DATA_W'(core_start), 1);
    tick();
    tick();
    core_valid = 1'b1;
    core_ct    = CTD;
    tick();
    chk("t6_rsp_valid2", DATA_W'(rsp_valid), 1);
    chk("t6_rsp_data2", rsp_data, CTD);
    chk("t6_rsp_meta2", DATA_W'({rsp_id, rsp_err}), 0);
    rsp_ready = 1'b1;
    tick();
    rsp_ready  = 1'b0;
    core_valid = 1'b0;
    #1;
    chk("t6_done_idle", DATA_W'(busy), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
